// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port, the shared-memory port and busy for mem_arbiter.
// The arbiter uses the slave modport; the requesters and the memory model use master.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for one single-port memory: grant in IDLE, LAT access cycles, one response cycle.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: data always wins).
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          owner_data_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          if_rvalid_q;
  logic          d_rvalid_q;
  logic          busy_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic          prefer_data_q;
`endif

  logic pick_data;
  logic grant_any;

  // Winner selection; a grant raised while RST is high would be lost, so it is suppressed.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.d_req && bus.if_req) begin
      pick_data = prefer_data_q;
    end else begin
      pick_data = bus.d_req;
    end
`else
    pick_data = bus.d_req;
`endif
    grant_any = (state_q == IDLE) && !RST && (bus.d_req || bus.if_req);
  end

  assign bus.d_gnt     = grant_any && pick_data;
  assign bus.if_gnt    = grant_any && !pick_data;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.busy      = busy_q;

  // Transaction FSM; memory-side and response outputs are all registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_data_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prefer_data_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q      <= ACCESS;
            cnt_q        <= CNT_INIT;
            owner_data_q <= pick_data;
            mem_en_q     <= 1'b1;
            mem_we_q     <= pick_data && bus.d_we;
            mem_addr_q   <= pick_data ? bus.d_addr : bus.if_addr;
            mem_wdata_q  <= pick_data ? bus.d_wdata : '0;
            busy_q       <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_data_q <= !pick_data;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_data_q) begin
              d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= bus.mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LAT=2 instance (fetch, store/load, tie, reset abort)
// and LAT=1 instance (back-to-back fetches). Responses are checked by a separate monitor.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [31:0] mem_a [0:63];
  bit          mem_loaded = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(2)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a.slave));
  mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b.slave));

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model for instance A: preloaded once, written on store access cycles.
  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= init_word(32'(i * 4));
      mem_loaded <= 1'b1;
    end else if (bus_a.mem_en && bus_a.mem_we) begin
      mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wdata;
    end
  end
  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[7:2]];
  assign bus_b.mem_rdata = init_word(bus_b.mem_addr);

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_loop();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus_a.if_rvalid || bus_a.d_rvalid) begin
        check1("a_rvalid_exclusive", bus_a.if_rvalid && bus_a.d_rvalid, 1'b0);
        if (q_a.size() == 0) begin
          fail("a_unexpected_rvalid");
        end else begin
          e = q_a.pop_front();
          check1("a_resp_side", bus_a.d_rvalid, e.is_data);
          check("a_rdata", e.is_data ? bus_a.d_rdata : bus_a.if_rdata, e.data);
          check_int("a_rvalid_cycle", cyc, e.cyc);
        end
      end
      if (bus_b.if_rvalid || bus_b.d_rvalid) begin
        if (q_b.size() == 0) begin
          fail("b_unexpected_rvalid");
        end else begin
          e = q_b.pop_front();
          check1("b_resp_side", bus_b.d_rvalid, e.is_data);
          check("b_rdata", e.is_data ? bus_b.d_rdata : bus_b.if_rdata, e.data);
          check_int("b_rvalid_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic wait_gnt_a(input bit data, output int g, output bit got);
    got = 1'b0;
    g = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (data ? bus_a.d_gnt : bus_a.if_gnt) begin
        got = 1'b1;
        g = cyc;
        check1("a_other_gnt_low", data ? bus_a.if_gnt : bus_a.d_gnt, 1'b0);
      end else begin
        @(negedge CLK);
      end
    end
    if (!got) fail("a_gnt_timeout");
  endtask

  task automatic txn_a(input bit data, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    int c0;
    int g;
    bit got;
    exp_t e;
    c0 = cyc;
    if (data) begin
      bus_a.d_req = 1'b1; bus_a.d_we = we; bus_a.d_addr = addr; bus_a.d_wdata = wd;
    end else begin
      bus_a.if_req = 1'b1; bus_a.if_addr = addr;
    end
    wait_gnt_a(data, g, got);
    if (got) begin
      check_int("a_gnt_cycle", g, c0);
      e.is_data = data; e.data = exp_rd; e.cyc = g + 3;
      q_a.push_back(e);
    end
    @(negedge CLK);
    bus_a.d_req = 1'b0;
    bus_a.if_req = 1'b0;
    if (got) begin
      for (int k = 0; k < 2; k++) begin
        check1("a_access_mem_en", bus_a.mem_en, 1'b1);
        check1("a_access_mem_we", bus_a.mem_we, we);
        check("a_access_mem_addr", bus_a.mem_addr, addr);
        check1("a_access_busy", bus_a.busy, 1'b1);
        if (we) check("a_access_mem_wdata", bus_a.mem_wdata, wd);
        @(negedge CLK);
      end
      check1("a_resp_mem_en", bus_a.mem_en, 1'b0);
      @(negedge CLK);
      check1("a_idle_busy", bus_a.busy, 1'b0);
    end
  endtask

  initial begin
    int c0;
    int g;
    int ngr;
    int d_want;
    int if_want;
    bit got;
    bit drop_d;
    bit drop_if;
    bit upd;
    logic [3:0] side_tab;
    exp_t e;

    bus_a.if_req = 1'b0; bus_a.if_addr = '0;
    bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0;
    bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
    RST = 1'b1;

    fork
      mon_loop();
      begin
        repeat (3) @(negedge CLK);
        check1("rst_if_gnt", bus_a.if_gnt, 1'b0);
        check1("rst_d_gnt", bus_a.d_gnt, 1'b0);
        check1("rst_if_rvalid", bus_a.if_rvalid, 1'b0);
        check1("rst_d_rvalid", bus_a.d_rvalid, 1'b0);
        check1("rst_mem_en", bus_a.mem_en, 1'b0);
        check1("rst_mem_we", bus_a.mem_we, 1'b0);
        check1("rst_busy", bus_a.busy, 1'b0);
        check("rst_mem_addr", bus_a.mem_addr, 32'h0);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'h0);
        check("rst_if_rdata", bus_a.if_rdata, 32'h0);
        check("rst_d_rdata", bus_a.d_rdata, 32'h0);
        check1("rst_b_busy", bus_b.busy, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // Fetch, then store followed by load of the same word.
        txn_a(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        txn_a(1'b1, 1'b1, 32'h20, 32'h1234, 32'h0);
        txn_a(1'b1, 1'b0, 32'h20, 32'h0, 32'h1234);
        check("a_if_rdata_hold", bus_a.if_rdata, 32'hDEADBEEF);

        // Both requesters held: two transactions each.
`ifdef ARB_ROUND_ROBIN_EN
        side_tab = 4'b0101;
`else
        side_tab = 4'b0011;
`endif
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h30;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40;
        c0 = cyc; ngr = 0; d_want = 2; if_want = 2; drop_d = 1'b0; drop_if = 1'b0;
        for (int k = 0; k < 40 && ngr < 4; k++) begin
          if (drop_d) begin bus_a.d_req = 1'b0; drop_d = 1'b0; end
          if (drop_if) begin bus_a.if_req = 1'b0; drop_if = 1'b0; end
          #1;
          if (bus_a.d_gnt || bus_a.if_gnt) begin
            check1("tie_single_gnt", bus_a.d_gnt && bus_a.if_gnt, 1'b0);
            check1("tie_side", bus_a.d_gnt, side_tab[ngr]);
            check_int("tie_gnt_cycle", cyc - c0, ngr * 4);
            e.is_data = bus_a.d_gnt;
            e.data = bus_a.d_gnt ? init_word(32'h30) : init_word(32'h40);
            e.cyc = cyc + 3;
            q_a.push_back(e);
            if (bus_a.d_gnt) begin
              d_want--;
              if (d_want == 0) drop_d = 1'b1;
            end else begin
              if_want--;
              if (if_want == 0) drop_if = 1'b1;
            end
            ngr++;
          end
          @(negedge CLK);
        end
        if (ngr < 4) fail("tie_timeout");
        bus_a.d_req = 1'b0;
        bus_a.if_req = 1'b0;
        repeat (4) @(negedge CLK);

        // Reset in the second access cycle aborts the fetch.
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40;
        wait_gnt_a(1'b0, g, got);
        @(negedge CLK);
        bus_a.if_req = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check1("abort_mem_en", bus_a.mem_en, 1'b0);
        check1("abort_busy", bus_a.busy, 1'b0);
        check("abort_mem_addr", bus_a.mem_addr, 32'h0);
        RST = 1'b0;
        txn_a(1'b0, 1'b0, 32'h8, 32'h0, init_word(32'h8));

        // LAT=1 back-to-back fetches on instance B.
        bus_b.if_req = 1'b1; bus_b.if_addr = 32'h0;
        c0 = cyc; ngr = 0; upd = 1'b0;
        for (int k = 0; k < 20 && ngr < 2; k++) begin
          if (upd) begin bus_b.if_addr = 32'h4; upd = 1'b0; end
          #1;
          if (bus_b.if_gnt) begin
            check_int("b_gnt_cycle", cyc - c0, ngr * 3);
            e.is_data = 1'b0;
            e.data = (ngr == 0) ? init_word(32'h0) : init_word(32'h4);
            e.cyc = cyc + 2;
            q_b.push_back(e);
            ngr++;
            upd = 1'b1;
          end
          @(negedge CLK);
        end
        if (ngr < 2) fail("b_gnt_timeout");
        bus_b.if_req = 1'b0;
        repeat (5) @(negedge CLK);

        check_int("a_queue_drained", q_a.size(), 0);
        check_int("b_queue_drained", q_b.size(), 0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port instruction/data memory in the multicycle CPU. The instruction-fetch path and the load/store path each raise a request; the arbiter selects one, drives the memory for a fixed access latency, then returns read data or a write acknowledgement. It sits between the controller-driven IR/memory datapath and the unified memory, and replaces separate instruction and data memory instances.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width.
- LAT, 2: memory access cycles per transaction; legal range 1–15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- if_req  in  1  instruction fetch request; held until if_gnt.
- if_addr  in  AW  fetch address; stable while if_req high.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DW  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- d_rdata  out  DW  load data; 0 for stores.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid at end of last access cycle.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - ACCESS: memory driven for LAT cycles.
  - RESP: one-cycle response.
- IDLE:
  - If any request is pending, pick a winner and assert its gnt combinationally in that cycle.
  - Latch addr, we and wdata of the winner and record the owner.
  - Load a down-counter with LAT-1 and go to ACCESS.
  - No request: stay in IDLE, all gnt low.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the latched registers and are stable for all LAT cycles.
  - Counter decrements each cycle. When it is 0, capture mem_rdata (loads/fetches) or 0 (stores) into the owner's rdata register and go to RESP.
- RESP:
  - Owner's rvalid=1 for exactly one cycle; mem_en=0.
  - Return to IDLE. No grant is issued in RESP.
- rdata registers hold their value until the next response to the same requester.
- Only one transaction is outstanding at a time. A request arriving during ACCESS/RESP waits; requesters must not drop req before gnt.
- Fetches never write: if_req implies mem_we=0.
- Arbitration is fixed priority (data over fetch) unless the configuration macro is defined.

## Timing
- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; state = IDLE; RR pointer = data-first.
- Grant cycle T (IDLE) → ACCESS cycles T+1..T+LAT → rvalid at T+LAT+1 → IDLE at T+LAT+2.
- Earliest next grant is T+LAT+2; sustained throughput is one transaction per LAT+2 cycles.
- LAT=1: a single ACCESS cycle; the counter loads 0.
- Simultaneous if_req and d_req in IDLE: exactly one gnt; the loser is granted at the next IDLE cycle.
- RST during ACCESS or RESP: the transaction is aborted at the next edge, no rvalid is issued, memory outputs return to 0, and the arbiter restarts in IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a one-bit pointer selects the winner when both requests are present.
  - The side not served last wins.
  - The pointer updates on every grant.
  - On reset the pointer favours data.
- Not defined: d_req always wins a tie. The fetch path is served only when d_req is low in the IDLE cycle. No pointer register exists.

## Test plan
- LAT=2, if_req addr 0x10, memory word 0xDEADBEEF: if_gnt at cycle 0, mem_en in cycles 1–2, if_rvalid with 0xDEADBEEF at cycle 3, busy low at cycle 4.
- Store d_addr 0x20, d_wdata 0x1234, then load 0x20: mem_we=1 only during the store's ACCESS; d_rvalid with d_rdata=0 for the store, then d_rdata=0x1234 for the load.
- Both requests held continuously, macro off: d_gnt on every grant, if_gnt never asserted until d_req drops.
- Both requests held continuously, ARB_ROUND_ROBIN_EN on: grants alternate d, if, d, if at cycles 0, 4, 8, 12 (LAT=2).
- RST asserted in the second ACCESS cycle: no rvalid, mem_en=0 and busy=0 next cycle; a fresh if_req is granted the cycle after reset deasserts.
- LAT=1 back-to-back fetches 0x0 and 0x4: grants at cycles 0 and 3, rvalids at cycles 2 and 5.
